// File: rtl/load_unpack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_unpack_pkg                                                      |
// | Shared funct3 load/store encodings, load FSM states, decode helpers. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package load_unpack_pkg;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    WAIT0 = 3'd2,
    RD1   = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      c_f3_lb, c_f3_lh, c_f3_lw, c_f3_lbu, c_f3_lhu: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // True when the access straddles a word boundary and needs a second read.
  function automatic logic access_is_split(input logic [2:0] op, input logic [1:0] offset);
    case (op)
      c_f3_lh, c_f3_lhu: return (offset == 2'd3);
      c_f3_lw:           return (offset != 2'd0);
      default:           return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_extract                                                         |
// | Selects the byte/halfword/word at offset and sign/zero extends it.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module load_extract
  import load_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] word_pair,
  input  logic [1:0]              offset,
  input  logic [2:0]              op,
  output logic [DATA_WIDTH-1:0]   ld_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = word_pair[{offset, 3'b000} +: DATA_WIDTH];

  always_comb begin
    ld_data = '0;
    case (op)
      c_f3_lb:  ld_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      c_f3_lh:  ld_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      c_f3_lw:  ld_data = w_shifted;
      c_f3_lbu: ld_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      c_f3_lhu: ld_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default:  ld_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_unpack                                                          |
// | Single-outstanding load unit: word reads, split handling, extension. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module load_unpack #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_op,
  output logic                  req_ready,
  output logic                  mem_rd_valid,
  output logic [DATA_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_err,
  input  logic                  ld_ready
);

  import load_unpack_pkg::*;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_word0;
  logic [DATA_WIDTH-1:0] r_word1;
  logic [DATA_WIDTH-1:0] r_mem_rd_addr;
  logic [2:0]            r_op;
  logic                  r_err;
  logic                  w_split;

  assign w_split = access_is_split(r_op, r_addr[1:0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid)     w_state_nxt = op_is_legal(req_op) ? RD0 : DONE;
      RD0:     if (mem_rd_ready)  w_state_nxt = WAIT0;
      WAIT0:   if (mem_rsp_valid) w_state_nxt = w_split ? RD1 : DONE;
      RD1:     if (mem_rd_ready)  w_state_nxt = WAIT1;
      WAIT1:   if (mem_rsp_valid) w_state_nxt = DONE;
      DONE:    if (ld_ready)      w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_op          <= '0;
      r_word0       <= '0;
      r_word1       <= '0;
      r_mem_rd_addr <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr        <= req_addr;
            r_op          <= req_op;
            r_mem_rd_addr <= {req_addr[DATA_WIDTH-1:2], 2'b00};
            // Clearing both words makes word1 read as zero for unsplit loads.
            r_word0       <= '0;
            r_word1       <= '0;
            r_err         <= ~op_is_legal(req_op);
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            r_word0 <= mem_rsp_data;
            if (w_split) r_mem_rd_addr <= r_mem_rd_addr + DATA_WIDTH'(4);
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) r_word1 <= mem_rsp_data;
        end
        DONE: begin
          if (ld_ready) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign mem_rd_valid = (r_state == RD0) || (r_state == RD1);
  assign mem_rd_addr  = r_mem_rd_addr;
  assign ld_valid     = (r_state == DONE);
  assign ld_err       = r_err;

  // Words and op only change on accept/response, so ld_data holds through DONE.
  load_extract #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extract (
    .word_pair ({r_word1, r_word0}),
    .offset    (r_addr[1:0]),
    .op        (r_op),
    .ld_data   (ld_data)
  );

endmodule
`default_nettype wire

// File: doc/load_unpack.md
LOAD_UNPACK -- requirements
Module: load_unpack

Interface
REQ-001 The parameter SHALL be: DATA_WIDTH, 32, width of the address, memory word and load result.
REQ-002 The clock and reset SHALL be: one clock; reset is synchronous and active-high; clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 The load request inputs SHALL be: req_valid  in  1  load request; req_addr  in  32  byte address; req_op  in  3  funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
REQ-004 The load request output SHALL be: req_ready  out  1  request accepted when high with req_valid.
REQ-005 The memory read request ports SHALL be: mem_rd_valid  out  1  read request; mem_rd_addr  out  32  word-aligned address; mem_rd_ready  in  1  read accepted.
REQ-006 The memory response ports SHALL be: mem_rsp_valid  in  1  read data valid, one pulse per accepted read, in order; mem_rsp_data  in  32  little-endian word.
REQ-007 The result ports SHALL be: ld_valid  out  1  result valid; ld_data  out  32  extended load value; ld_err  out  1  illegal req_op; ld_ready  in  1  result consumed.

Function
REQ-008 The unit SHALL use an FSM with states IDLE, RD0, WAIT0, RD1, WAIT1, DONE and SHALL hold at most one load in flight.
REQ-009 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, the unit SHALL latch addr and op, going to RD0, or to DONE with ld_err=1 if op is illegal.
REQ-010 In RD0, mem_rd_valid=1 and mem_rd_addr={addr[31:2],2'b00}, held stable until mem_rd_ready; on acceptance the FSM SHALL go to WAIT0.
REQ-011 In WAIT0, on mem_rsp_valid the unit SHALL capture word0 and SHALL go to RD1 if the access is split, otherwise to DONE.
REQ-012 An access is split exactly when lh/lhu has offset 3 or lw has offset 1, 2 or 3, where offset=addr[1:0].
REQ-013 In RD1/WAIT1, the unit SHALL read word1 at mem_rd_addr={addr[31:2],2'b00}+4, wrapping modulo 2^32 so that 0xFFFFFFFC+4 gives 0x00000000, then SHALL go to DONE.
REQ-014 Extraction: ld_data SHALL be the low byte, halfword or word of ({word1,word0} >> 8*offset), with word1=0 for non-split accesses.
REQ-015 Extension: lb and lh SHALL sign-extend, lbu and lhu SHALL zero-extend, and lw SHALL pass 32 bits.
REQ-016 In DONE, ld_valid=1 and ld_data/ld_err SHALL be held stable until ld_ready; on ld_ready the FSM SHALL return to IDLE, and a new request SHALL NOT be accepted in that same cycle.
REQ-017 An illegal op SHALL give ld_data=0 and ld_err=1 with no memory access; legal ops SHALL give ld_err=0.
REQ-018 mem_rsp_valid outside WAIT0/WAIT1 SHALL be ignored.
REQ-019 Minimum latency for an aligned load with mem_rd_ready=1 and response one cycle after acceptance SHALL be 3 cycles from request accept to ld_valid; a split load SHALL add 2 cycles.
REQ-020 mem_rd_valid SHALL be 0 in every state other than RD0/RD1.

Reset
REQ-021 On rst, the FSM SHALL go to IDLE and req_ready=1, while mem_rd_valid, ld_valid and ld_err SHALL be 0 and ld_data, mem_rd_addr and the captured words SHALL be 0.
REQ-022 Reset mid-operation SHALL abandon the load without producing ld_valid, and a response arriving after reset SHALL be ignored per REQ-018.
REQ-023 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-024 The funct3 load encodings and the FSM state enum SHALL live in a shared package, alongside the store encodings.
REQ-025 Extraction and extension (REQ-014, REQ-015) SHALL be a combinational sub-module load_extract with inputs {word1,word0}, offset and op, and output ld_data.
REQ-026 All FSM state and the registered outputs SHALL be updated only on the rising edge of clk.

Verification
REQ-027 lbu at 0x103 with word 0x80FF1234 SHALL give ld_data=0x00000080 after 3 cycles with 1 read at 0x100.
REQ-028 lb at 0x103 with word 0x80FF1234 SHALL give 0xFFFFFF80; lh at 0x102 SHALL give 0xFFFF80FF; lhu SHALL give 0x000080FF.
REQ-029 lw at 0x1FE with word0 0xAABBCCDD and word1 0x11223344 SHALL read 0x1FC then 0x200 and give ld_data=0x3344AABB.
REQ-030 lw at 0xFFFFFFFF SHALL read 0xFFFFFFFC then 0x00000000 to show the wrap; req_op=011 SHALL give ld_err=1 and ld_data=0 with mem_rd_valid never asserted.
REQ-031 With mem_rd_ready held 0 for 4 cycles and ld_ready held 0 for 3 cycles, mem_rd_addr and ld_data SHALL stay stable and req_ready SHALL stay 0 until the DONE handshake.
REQ-032 rst asserted in WAIT0, followed by a late mem_rsp_valid, SHALL leave ld_valid=0 and IDLE with req_ready=1 on the next cycle.
